// File: rtl/ahb_timer_satellite.sv
// AHB-Lite timer satellite: 32-bit compare timer with prescaler, autoreload/one-shot and a level interrupt.
// Optional prescaler is built only when AHB_TIMER_PRESCALER_EN is defined; otherwise the timer ticks every enabled cycle.
module ahb_timer_satellite #(
    parameter int          PRESCALE_W    = 16,
    parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic        tim_int
);

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_PRESCALE = 3'd1;
    localparam logic [2:0] ADDR_COUNT    = 3'd2;
    localparam logic [2:0] ADDR_COMPARE  = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;

    logic        dp_valid;
    logic        dp_write;
    logic [2:0]  dp_addr;
    logic        ctrl_en;
    logic        ctrl_autoreload;
    logic        ctrl_ie;
    logic [31:0] count;
    logic [31:0] compare;
    logic        match;
    logic        tick;
    logic        hit;
    logic [31:0] prescale_rd;
    logic        wr_en;
    logic        unused_inputs;

    assign unused_inputs = ^{hsize, haddr[31:5], haddr[1:0], htrans[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
        end else begin
            dp_valid <= hsel & htrans[1] & hready;
            if (hsel && htrans[1] && hready) begin
                dp_addr  <= haddr[4:2];
                dp_write <= hwrite;
            end
        end
    end

    assign wr_en = dp_valid & dp_write;

`ifdef AHB_TIMER_PRESCALER_EN
    localparam logic [PRESCALE_W-1:0] PCNT_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale <= '0;
            pcnt     <= '0;
        end else begin
            if (wr_en && dp_addr == ADDR_PRESCALE) begin
                prescale <= hwdata[PRESCALE_W-1:0];
            end
            if (!ctrl_en || tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + PCNT_ONE;
            end
        end
    end

    // >= rather than == so lowering PRESCALE below the running count still ticks
    assign tick        = ctrl_en && (pcnt >= prescale);
    assign prescale_rd = 32'(prescale);
`else
    assign tick        = ctrl_en;
    assign prescale_rd = '0;
`endif

    assign hit = tick && (count == compare);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en         <= 1'b0;
            ctrl_autoreload <= 1'b0;
            ctrl_ie         <= 1'b0;
            count           <= '0;
            compare         <= RESET_COMPARE;
            match           <= 1'b0;
        end else begin
            if (tick) begin
                if (hit) begin
                    if (ctrl_autoreload) begin
                        count <= '0;
                    end else begin
                        ctrl_en <= 1'b0;
                    end
                end else begin
                    count <= count + 32'd1;
                end
            end
            // NOTE: with non-blocking assignments the last one in the block wins,
            // so placing bus writes after the tick update gives the bus priority.
            if (wr_en && dp_addr == ADDR_CTRL) begin
                ctrl_en         <= hwdata[0];
                ctrl_autoreload <= hwdata[1];
                ctrl_ie         <= hwdata[2];
            end
            if (wr_en && dp_addr == ADDR_COUNT) begin
                count <= hwdata;
            end
            if (wr_en && dp_addr == ADDR_COMPARE) begin
                compare <= hwdata;
            end
            if (hit) begin
                match <= 1'b1;
            end else if (wr_en && dp_addr == ADDR_STATUS && hwdata[0]) begin
                match <= 1'b0;
            end
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns hrdata and no latch is inferred.
        hrdata = '0;
        if (dp_valid && !dp_write) begin
            case (dp_addr)
                ADDR_CTRL:     hrdata = {29'd0, ctrl_ie, ctrl_autoreload, ctrl_en};
                ADDR_PRESCALE: hrdata = prescale_rd;
                ADDR_COUNT:    hrdata = count;
                ADDR_COMPARE:  hrdata = compare;
                ADDR_STATUS:   hrdata = {31'd0, match};
                default:       hrdata = '0;
            endcase
        end
    end

    assign tim_int   = match & ctrl_ie;
    assign hreadyout = 1'b1;
    assign hresp     = 1'b0;

endmodule

// File: tb/tb_ahb_timer_satellite.sv
// Scoreboard bench for ahb_timer_satellite: read expectations are queued by the driver
// and compared by a separate monitor during each read data phase.
module tb_ahb_timer_satellite;

`ifdef AHB_TIMER_PRESCALER_EN
    localparam int P = 3;
`else
    localparam int P = 0;
`endif

    logic        clk;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
    logic        tim_int;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic rd_pending = 1'b0;

    ahb_timer_satellite dut (
        .clk       (clk),
        .rst       (rst),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hready    (hready),
        .hrdata    (hrdata),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .tim_int   (tim_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a read address phase seen at a rising edge means a data phase follows.
    always @(posedge clk) begin
        rd_pending <= !rst && hsel && htrans[1] && hready && !hwrite;
    end

    always @(negedge clk) begin
        if (rd_pending && !rst) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read", hrdata, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, hrdata, e.val);
                check({e.name, "_hresp"}, {31'd0, hresp}, 32'd0);
            end
        end
    end

    task automatic push_exp(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    task automatic addr_phase(input logic [31:0] addr, input logic wr);
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = addr;
        hwrite = wr;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        addr_phase(addr, 1'b1);
        wait_cycles(1);
        bus_idle();
        hwdata = data;
        wait_cycles(1);
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        push_exp(name, exp);
        addr_phase(addr, 1'b0);
        wait_cycles(1);
        bus_idle();
        wait_cycles(1);
    endtask

    task automatic do_reset();
        bus_idle();
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        hsel   = 1'b0;
        haddr  = '0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'b010;
        hwdata = '0;
        hready = 1'b1;
        wait_cycles(1);
        check("reset_hrdata_during_rst", hrdata, 32'd0);
        do_reset();

        // Reset state
        check("reset_tim_int", {31'd0, tim_int}, 32'd0);
        check("reset_hreadyout", {31'd0, hreadyout}, 32'd1);
        check("reset_hresp", {31'd0, hresp}, 32'd0);
        bus_read(32'h00, 32'd0, "reset_ctrl");
        bus_read(32'h04, 32'd0, "reset_prescale");
        bus_read(32'h08, 32'd0, "reset_count");
        bus_read(32'h0C, 32'hFFFF_FFFF, "reset_compare");
        bus_read(32'h10, 32'd0, "reset_status");

        // Autoreload, COMPARE=4: COUNT runs 0..4 and MATCH sets every 5 cycles
        bus_write(32'h04, 32'd0);
        bus_write(32'h0C, 32'd4);
        bus_write(32'h00, 32'h7);
        for (int i = 0; i < 10; i++) begin
            push_exp("ar_count_seq", 32'((i + 1) % 5));
            addr_phase(32'h08, 1'b0);
            wait_cycles(1);
        end
        bus_idle();
        wait_cycles(1);
        check("ar_tim_int_set", {31'd0, tim_int}, 32'd1);
        bus_write(32'h10, 32'd1);
        check("ar_w1c_tim_int_low", {31'd0, tim_int}, 32'd0);
        wait_cycles(2);
        check("ar_rematch_tim_int", {31'd0, tim_int}, 32'd1);

        // One-shot: third tick detects COUNT==COMPARE after 3*(P+1) cycles
        do_reset();
        bus_write(32'h04, 32'd3);
        bus_read(32'h04, 32'(P), "os_prescale_readback");
        bus_write(32'h0C, 32'd2);
        bus_write(32'h00, 32'h5);
        wait_cycles(3 * P + 2);
        check("os_tim_int_before", {31'd0, tim_int}, 32'd0);
        wait_cycles(1);
        check("os_tim_int_after", {31'd0, tim_int}, 32'd1);
        bus_read(32'h00, 32'h4, "os_ctrl_en_cleared");
        bus_read(32'h08, 32'd2, "os_count_held");
        wait_cycles(20);
        bus_read(32'h08, 32'd2, "os_count_still_held");
        bus_read(32'h10, 32'd1, "os_status_match");

        // Wrap from FFFF_FFFF and bus write colliding with a tick
        do_reset();
        bus_write(32'h08, 32'hFFFF_FFFF);
        bus_write(32'h0C, 32'd5);
        bus_write(32'h00, 32'h1);
        bus_read(32'h08, 32'd0, "wrap_count_zero");
        bus_read(32'h10, 32'd0, "wrap_no_match");
        bus_write(32'h08, 32'h100);
        bus_read(32'h08, 32'h101, "collide_count_write_wins");

        // W1C in the same cycle as a new match: set wins
        do_reset();
        bus_write(32'h0C, 32'd2);
        bus_write(32'h00, 32'h7);
        wait_cycles(4);
        bus_write(32'h10, 32'd1);
        check("w1c_collide_tim_int", {31'd0, tim_int}, 32'd1);
        bus_read(32'h10, 32'd1, "w1c_collide_status");
        bus_write(32'h18, 32'hDEAD_BEEF);
        bus_read(32'h18, 32'd0, "unmapped_0x18");

        // Asynchronous reset mid-count
        do_reset();
        bus_write(32'h08, 32'h37);
        bus_write(32'h00, 32'h7);
        addr_phase(32'h08, 1'b0);
        wait_cycles(1);
        bus_idle();
        check("midcount_hrdata", hrdata, 32'h38);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_hrdata", hrdata, 32'd0);
        check("async_rst_tim_int", {31'd0, tim_int}, 32'd0);
        check("async_rst_hreadyout", {31'd0, hreadyout}, 32'd1);
        check("async_rst_hresp", {31'd0, hresp}, 32'd0);
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(1);
        bus_read(32'h08, 32'd0, "post_rst_count");
        wait_cycles(5);
        bus_read(32'h08, 32'd0, "post_rst_count_idle");
        bus_read(32'h00, 32'd0, "post_rst_ctrl");
        bus_read(32'h0C, 32'hFFFF_FFFF, "post_rst_compare");
        bus_write(32'h00, 32'h1);
        bus_read(32'h08, 32'd1, "post_rst_resume");

        wait_cycles(2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
